data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 37 +++
 rtl/data_mem_responder.sv | 112 +++++++++++
 tb/tb_data_mem_responder.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Bundles the CPU data-memory port and the byte-dump stream of
//   data_mem_responder.
//   Handshake: a dump byte moves on a rising clock edge when o_tx_valid and
//   i_tx_ready are both high. While o_tx_valid is high and i_tx_ready is low,
//   o_tx_valid and o_tx_data hold their values. i_tx_ready has no effect
//   while o_tx_valid is low.
//   slave  : the responder (drives o_* signals)
//   master : CPU / dump controller / UART side (drives i_* signals)
`timescale 1ns/1ps
interface data_mem_responder_if #(
   parameter int N_BUS    = 16,
   parameter int N_BUS_IN = 11
);
   logic [N_BUS_IN-1:0] i_Addr;
   logic [N_BUS-1:0]    i_In_Data;
   logic                i_WrRam;
   logic                i_RdRam;
   logic [N_BUS-1:0]    o_Out_Data;
   logic                i_dump_start;
   logic [N_BUS_IN-1:0] i_dump_last;
   logic [7:0]          o_tx_data;
   logic                o_tx_valid;
   logic                i_tx_ready;
   logic                o_dump_busy;
   logic                o_dump_done;

   modport slave (
      input  i_Addr, i_In_Data, i_WrRam, i_RdRam, i_dump_start, i_dump_last, i_tx_ready,
      output o_Out_Data, o_tx_data, o_tx_valid, o_dump_busy, o_dump_done
   );

   modport master (
      output i_Addr, i_In_Data, i_WrRam, i_RdRam, i_dump_start, i_dump_last, i_tx_ready,
      input  o_Out_Data, o_tx_data, o_tx_valid, o_dump_busy, o_dump_done
   );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data memory of 2^N_BUS_IN words of N_BUS (=16) bits with a zero-latency
//   CPU read/write port, plus a dump engine that streams words 0..last as
//   big-endian byte pairs to a UART transmitter. The CPU port is never
//   stalled by a dump.
// Ports:
//   i_clk       : single clock, rising edge
//   i_reset     : asynchronous, active-high; does not touch memory contents
//   bus         : data_mem_responder_if.slave (CPU port + dump stream)
//   o_dbg_state : current dump FSM state encoding
`timescale 1ns/1ps
module data_mem_responder #(
   parameter int N_BUS    = 16,
   parameter int N_BUS_IN = 11
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   data_mem_responder_if.slave    bus,
   output logic [2:0]             o_dbg_state
);
   localparam int DEPTH = 1 << N_BUS_IN;
   localparam logic [N_BUS_IN-1:0] PTR_ONE = 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SEND_HI = 3'd2,
      SEND_LO = 3'd3,
      DONE    = 3'd4
   } state_t;

   logic [N_BUS-1:0]    mem [DEPTH];
   state_t              state_q, state_d;
   logic [N_BUS_IN-1:0] ptr_q, last_q;
   logic [N_BUS-1:0]    word_q;
   logic [7:0]          tx_data;
   logic                tx_valid, dump_busy, dump_done;

   // Memory has no reset: contents survive i_reset.
   always_ff @(posedge i_clk) begin
      if (bus.i_WrRam) mem[bus.i_Addr] <= bus.i_In_Data;
   end

   // Asynchronous read: a same-cycle write shows the old word until the edge.
   assign bus.o_Out_Data = bus.i_RdRam ? mem[bus.i_Addr] : '0;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      dump_busy = 1'b1;
      dump_done = 1'b0;
      case (state_q)
         IDLE: begin
            dump_busy = 1'b0;
            if (bus.i_dump_start) state_d = LOAD;
         end
         LOAD: state_d = SEND_HI;
         SEND_HI: begin
            tx_valid = 1'b1;
            tx_data  = word_q[N_BUS-1:N_BUS/2];
            if (bus.i_tx_ready) state_d = SEND_LO;
         end
         SEND_LO: begin
            tx_valid = 1'b1;
            tx_data  = word_q[N_BUS/2-1:0];
            if (bus.i_tx_ready) state_d = (ptr_q == last_q) ? DONE : LOAD;
         end
         DONE: begin
            dump_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Dump datapath. The word is captured in LOAD, so later CPU writes to
   // that address cannot change bytes already in flight. The pointer stops
   // at last (compare before increment), so it never wraps.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ptr_q  <= '0;
         last_q <= '0;
         word_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.i_dump_start) begin
                  last_q <= bus.i_dump_last;
                  ptr_q  <= '0;
               end
            end
            LOAD:    word_q <= mem[ptr_q];
            SEND_LO: begin
               if (bus.i_tx_ready && (ptr_q != last_q)) ptr_q <= ptr_q + PTR_ONE;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_tx_valid  = tx_valid;
   assign bus.o_tx_data   = tx_data;
   assign bus.o_dump_busy = dump_busy;
   assign bus.o_dump_done = dump_done;
   assign o_dbg_state     = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;
   localparam int N_BUS    = 16;
   localparam int N_BUS_IN = 11;
   localparam int DEPTH    = 1 << N_BUS_IN;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;

   data_mem_responder_if #(.N_BUS(N_BUS), .N_BUS_IN(N_BUS_IN)) bus ();

   data_mem_responder #(.N_BUS(N_BUS), .N_BUS_IN(N_BUS_IN)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain array of words and the expected byte stream.
   logic [15:0] model_mem [DEPTH];
   logic [7:0]  exp_q[$];

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_Addr       = '0;
      bus.i_In_Data    = '0;
      bus.i_WrRam      = 1'b0;
      bus.i_RdRam      = 1'b0;
      bus.i_dump_start = 1'b0;
      bus.i_dump_last  = '0;
      bus.i_tx_ready   = 1'b0;
   endtask

   task automatic cpu_write(input logic [10:0] a, input logic [15:0] d);
      bus.i_Addr = a; bus.i_In_Data = d; bus.i_WrRam = 1'b1;
      tick();
      bus.i_WrRam = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   // Runs one dump. exp_q must hold the expected bytes. mode: 0 ready high,
   // 1 random ready, 2 ready low for cycles 2..5. Cycle k counts from the
   // edge that samples i_dump_start.
   task automatic run_dump(input int last, input int mode, input int restart_k,
                           input int wr_k, input logic [10:0] wr_a, input logic [15:0] wr_d,
                           input bit traffic,
                           output int done_k, output int busy_n, output int stalls);
      int budget, k;
      bit finished, hold, do_wr;
      logic [7:0] hold_data;
      logic [10:0] a;
      budget = 20 * (last + 1) + 50;
      done_k = -1; busy_n = 0; stalls = 0; finished = 0; hold = 0; hold_data = 8'h00;
      bus.i_dump_last = last[10:0];
      bus.i_dump_start = 1'b1;
      bus.i_tx_ready = 1'b1;
      tick();
      bus.i_dump_start = 1'b0;
      k = 1;
      while (!finished && k <= budget) begin
         case (mode)
            0: bus.i_tx_ready = 1'b1;
            1: bus.i_tx_ready = 1'($urandom_range(0, 1));
            default: bus.i_tx_ready = !(k >= 2 && k <= 5);
         endcase
         if (k == restart_k) begin
            bus.i_dump_start = 1'b1; bus.i_dump_last = 11'd3;
         end else bus.i_dump_start = 1'b0;
         do_wr = 0;
         if (k == wr_k) begin
            do_wr = 1; bus.i_Addr = wr_a; bus.i_In_Data = wr_d; bus.i_RdRam = 1'b1;
         end else if (traffic) begin
            do_wr = (last < DEPTH - 1) && ($urandom_range(0, 2) == 0);
            if (do_wr) a = 11'(last + 1 + $urandom_range(0, DEPTH - 2 - last));
            else       a = 11'($urandom_range(0, DEPTH - 1));
            bus.i_Addr = a; bus.i_In_Data = 16'($urandom);
            bus.i_RdRam = 1'($urandom_range(0, 1));
         end else bus.i_RdRam = 1'b0;
         bus.i_WrRam = do_wr;
         #1;
         if (traffic || k == wr_k) begin
            n_checks++;
            if (bus.o_Out_Data !== (bus.i_RdRam ? model_mem[bus.i_Addr] : 16'h0)) begin
               n_fail++;
               $display("FAIL dump_cpu_read k=%0d addr=%0d: got %h expected %h", k, bus.i_Addr,
                        bus.o_Out_Data, bus.i_RdRam ? model_mem[bus.i_Addr] : 16'h0);
            end
         end
         if (do_wr) model_mem[bus.i_Addr] = bus.i_In_Data;
         if (hold) begin
            n_checks++;
            if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== hold_data) begin
               n_fail++;
               $display("FAIL tx_stable k=%0d: got valid=%b data=%h expected valid=1 data=%h",
                        k, bus.o_tx_valid, bus.o_tx_data, hold_data);
            end
         end
         n_checks++;
         if (bus.o_tx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL tx_extra_byte k=%0d: got %h expected no byte", k, bus.o_tx_data);
            end else if (bus.o_tx_data !== exp_q[0]) begin
               n_fail++;
               $display("FAIL tx_byte k=%0d: got %h expected %h", k, bus.o_tx_data, exp_q[0]);
            end
         end else if (bus.o_tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL tx_idle_data k=%0d: got %h expected 00", k, bus.o_tx_data);
         end
         if (bus.o_dump_busy === 1'b1) busy_n++;
         if (bus.o_dump_done === 1'b1) begin
            n_checks++;
            if (exp_q.size() != 0) begin
               n_fail++;
               $display("FAIL done_early k=%0d: got %0d bytes left expected 0", k, exp_q.size());
            end
            done_k = k; finished = 1;
         end
         hold = 0;
         if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end else if (bus.o_tx_valid === 1'b1) begin
            hold = 1; hold_data = bus.o_tx_data; stalls++;
         end
         tick();
         k++;
      end
      bus.i_WrRam = 1'b0; bus.i_RdRam = 1'b0; bus.i_dump_start = 1'b0; bus.i_dump_last = '0;
      n_checks++;
      if (!finished) begin
         n_fail++;
         $display("FAIL dump_timeout: got no done in %0d cycles expected done", budget);
      end else begin
         #1;
         if (bus.o_dump_done !== 1'b0 || bus.o_dump_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_end: got done=%b busy=%b expected 0 0",
                     bus.o_dump_done, bus.o_dump_busy);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      #2;
      n_checks++;
      if ({bus.o_tx_valid, bus.o_tx_data, bus.o_dump_busy, bus.o_dump_done, bus.o_Out_Data} !== 27'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b data=%h busy=%b done=%b out=%h expected all 0",
                  bus.o_tx_valid, bus.o_tx_data, bus.o_dump_busy, bus.o_dump_done, bus.o_Out_Data);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic fill_memory();
      for (int a = 0; a < DEPTH; a++) cpu_write(11'(a), 16'($urandom));
   endtask

   task automatic test_cpu_rw();
      cpu_write(11'd5, 16'hBEEF);
      bus.i_Addr = 11'd5; bus.i_RdRam = 1'b1; #1;
      n_checks++;
      if (bus.o_Out_Data !== 16'hBEEF) begin
         n_fail++; $display("FAIL read_beef: got %h expected BEEF", bus.o_Out_Data);
      end
      bus.i_RdRam = 1'b0; #1;
      n_checks++;
      if (bus.o_Out_Data !== 16'h0000) begin
         n_fail++; $display("FAIL read_disabled: got %h expected 0000", bus.o_Out_Data);
      end
      tick();
   endtask

   task automatic test_same_cycle_rw();
      cpu_write(11'd7, 16'h0042);
      bus.i_Addr = 11'd7; bus.i_In_Data = 16'h1234; bus.i_WrRam = 1'b1; bus.i_RdRam = 1'b1; #1;
      n_checks++;
      if (bus.o_Out_Data !== 16'h0042) begin
         n_fail++; $display("FAIL same_cycle_old: got %h expected 0042", bus.o_Out_Data);
      end
      tick();
      bus.i_WrRam = 1'b0; model_mem[7] = 16'h1234; #1;
      n_checks++;
      if (bus.o_Out_Data !== 16'h1234) begin
         n_fail++; $display("FAIL same_cycle_new: got %h expected 1234", bus.o_Out_Data);
      end
      bus.i_RdRam = 1'b0;
      tick();
   endtask

   task automatic test_random_rw();
      for (int i = 0; i < 60; i++) begin
         bus.i_Addr = 11'($urandom_range(0, 15));
         bus.i_In_Data = 16'($urandom);
         bus.i_WrRam = 1'($urandom_range(0, 1));
         bus.i_RdRam = 1'($urandom_range(0, 1));
         #1;
         n_checks++;
         if (bus.o_Out_Data !== (bus.i_RdRam ? model_mem[bus.i_Addr] : 16'h0)) begin
            n_fail++;
            $display("FAIL random_rw addr=%0d: got %h expected %h", bus.i_Addr, bus.o_Out_Data,
                     bus.i_RdRam ? model_mem[bus.i_Addr] : 16'h0);
         end
         if (bus.i_WrRam) model_mem[bus.i_Addr] = bus.i_In_Data;
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_dump_basic(input int mode, input int restart_k, input int exp_done);
      int done_k, busy_n, stalls;
      cpu_write(11'd0, 16'hA1B2);
      cpu_write(11'd1, 16'hC3D4);
      exp_q.delete();
      push_word(16'hA1B2); push_word(16'hC3D4);
      run_dump(1, mode, restart_k, -1, 11'd0, 16'h0, 0, done_k, busy_n, stalls);
      n_checks++;
      if (done_k !== exp_done || busy_n !== exp_done || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL dump_basic mode=%0d: got done=%0d busy=%0d left=%0d expected done=%0d busy=%0d left=0",
                  mode, done_k, busy_n, exp_q.size(), exp_done, exp_done);
      end
      tick();
   endtask

   task automatic test_dump_random(input int last, input int mode, input bit traffic);
      int done_k, busy_n, stalls;
      exp_q.delete();
      for (int w = 0; w <= last; w++) push_word(model_mem[w]);
      run_dump(last, mode, -1, -1, 11'd0, 16'h0, traffic, done_k, busy_n, stalls);
      n_checks++;
      if (done_k != 1 + 3 * (last + 1) + stalls || busy_n != done_k || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL dump_len last=%0d: got done=%0d busy=%0d left=%0d expected done=%0d",
                  last, done_k, busy_n, exp_q.size(), 1 + 3 * (last + 1) + stalls);
      end
      tick();
   endtask

   // A write landing on the LOAD edge of word 0 must not show; a write to
   // word 1 before its LOAD must show.
   task automatic test_write_after_load();
      int done_k, busy_n, stalls;
      logic [15:0] nw;
      nw = 16'($urandom);
      exp_q.delete();
      push_word(model_mem[0]); push_word(model_mem[1]);
      run_dump(1, 0, -1, 1, 11'd0, nw, 0, done_k, busy_n, stalls);
      n_checks++;
      if (done_k != 7 || model_mem[0] !== nw) begin
         n_fail++; $display("FAIL wr_during_load: got done=%0d expected 7", done_k);
      end
      tick();
      nw = 16'($urandom);
      exp_q.delete();
      push_word(model_mem[0]); push_word(nw);
      run_dump(1, 0, -1, 3, 11'd1, nw, 0, done_k, busy_n, stalls);
      n_checks++;
      if (done_k != 7) begin
         n_fail++; $display("FAIL wr_before_load: got done=%0d expected 7", done_k);
      end
      tick();
   endtask

   task automatic test_reset_mid_dump();
      bit done_seen;
      done_seen = 0;
      bus.i_dump_last = 11'd1; bus.i_dump_start = 1'b1; bus.i_tx_ready = 1'b1;
      tick();
      bus.i_dump_start = 1'b0;
      tick();
      tick();
      bus.i_tx_ready = 1'b0;
      #1;
      n_checks++;
      if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== model_mem[0][7:0]) begin
         n_fail++;
         $display("FAIL pre_reset_lo: got valid=%b data=%h expected 1 %h",
                  bus.o_tx_valid, bus.o_tx_data, model_mem[0][7:0]);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.o_tx_valid !== 1'b0 || bus.o_dump_busy !== 1'b0 || bus.o_tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b busy=%b data=%h expected 0 0 00",
                  bus.o_tx_valid, bus.o_dump_busy, bus.o_tx_data);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.o_dump_done === 1'b1) done_seen = 1;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.o_dump_done === 1'b1) done_seen = 1;
      end
      n_checks++;
      if (done_seen) begin
         n_fail++; $display("FAIL reset_no_done: got done pulse expected none");
      end
      bus.i_RdRam = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.i_Addr = (i < 2) ? 11'(i) : 11'($urandom_range(0, DEPTH - 1));
         #1;
         n_checks++;
         if (bus.o_Out_Data !== model_mem[bus.i_Addr]) begin
            n_fail++;
            $display("FAIL mem_after_reset addr=%0d: got %h expected %h", bus.i_Addr,
                     bus.o_Out_Data, model_mem[bus.i_Addr]);
         end
      end
      bus.i_RdRam = 1'b0;
      tick();
      test_dump_random(0, 0, 0);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      fill_memory();
      test_cpu_rw();
      test_same_cycle_rw();
      test_random_rw();
      test_dump_basic(0, -1, 7);
      test_dump_basic(2, -1, 11);
      test_dump_basic(0, 3, 7);
      test_dump_random(0, 0, 0);
      for (int i = 0; i < 4; i++) test_dump_random($urandom_range(2, 20), 1, 1);
      test_write_after_load();
      test_reset_mid_dump();
      test_dump_random(DEPTH - 1, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
